switch_allocator: RTL and testbench
===================================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter NUM_CHANNEL, default 5 (global.v), number of router ports; 4-Bypass, 3-N, 2-S, 1-E, 0-W.
REQ-002 Parameter LOG_NUM_PORT, default 3 (global.v), width of one port index.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 reqValid  in  NUM_CHANNEL  bit i: input i presents a flit.
REQ-007 reqDst  in  NUM_CHANNEL*LOG_NUM_PORT  field i (bits i*LOG_NUM_PORT+:LOG_NUM_PORT): requested output of input i.
REQ-008 reqTail  in  NUM_CHANNEL  bit i: the flit at input i is a tail (head+tail = single-flit packet).
REQ-009 outReady  in  NUM_CHANNEL  bit o: output o can accept a flit this cycle.
REQ-010 grant  out  NUM_CHANNEL  bit i: the flit at input i is granted this cycle (combinational).
REQ-011 allocVector  out  NUM_CHANNEL*NUM_CHANNEL  registered; bit i*NUM_CHANNEL+o = input i drives output o; feeds xbarCtrl.

Function
REQ-012 Input i SHALL be a candidate for output o iff reqValid[i]=1 and reqDst field i = o; a reqDst value >= NUM_CHANNEL SHALL be ignored (no grant).
REQ-013 Each output o SHALL hold one state: IDLE or LOCKED(owner), plus a round-robin pointer ptr[o] in 0..NUM_CHANNEL-1.
REQ-014 IDLE and outReady[o]=1: grant the first candidate scanning ptr[o], ptr[o]+1, ... modulo NUM_CHANNEL; no candidate or outReady[o]=0 means no grant.
REQ-015 LOCKED(L): grant only input L, and only if L is a candidate for o and outReady[o]=1; other candidates are blocked.
REQ-016 IDLE->LOCKED(i) on a grant to input i with reqTail[i]=0; a tail grant keeps IDLE.
REQ-017 LOCKED(L)->IDLE on a grant to L with reqTail[L]=1.
REQ-018 LOCKED is held while the owner deasserts reqValid or outReady[o]=0 (wormhole hold).
REQ-019 On any tail grant (including single-flit) from input i at output o: ptr[o] <= (i+1) mod NUM_CHANNEL, with 4 wrapping to 0; otherwise ptr[o] is unchanged.
REQ-020 grant[i] SHALL be asserted in the same cycle as the request; at most one grant per output and per input.
REQ-021 allocVector SHALL equal the cycle-t grants at cycle t+1: row i one-hot of reqDst[i] if grant[i], else all-zero row.
REQ-022 The NUM_CHANNEL outputs SHALL allocate independently and concurrently within one cycle.

Reset
REQ-023 While reset=1 at a clock edge: all outputs IDLE, all ptr=0, allocVector=0.
REQ-024 grant SHALL be 0 whenever reset=1.
REQ-025 Reset mid-packet SHALL drop all locks with no residual grants.

Structure
REQ-026 NUM_CHANNEL, LOG_NUM_PORT and the port-index encodings SHALL come from global.v; no local redefinition.
REQ-027 One sub-module rr_arbiter (NUM_CHANNEL-way request vector + pointer -> one-hot grant) SHALL be instantiated once per output.
REQ-028 Lock state, owner and pointer registers SHALL live in switch_allocator.

Verification
REQ-029 Reset, then inputs 0 and 2 request output 3 with single-flit packets, outReady=5'b11111 -> cycle 1: grant=5'b00001, ptr[3]=1; cycle 2: grant=5'b00100, ptr[3]=3; allocVector lags one cycle.
REQ-030 Input 1 sends head, body, tail to output 4 while input 3 also requests 4 -> input 3 is blocked for 3 cycles; in cycle 4 input 3 is granted; ptr[4]=2 after the tail.
REQ-031 Input 4 is locked to output 0; outReady[0]=0 for 2 cycles and reqValid[4]=0 for 1 cycle -> no grants, lock retained; resumes on input 4 only.
REQ-032 ptr[2]=4; inputs 0 and 4 request output 2 with tails -> input 4 granted first; ptr[2] wraps to 0; input 0 granted next.
REQ-033 Five inputs request distinct outputs (i->(i+1) mod 5) simultaneously -> grant=5'b11111; next cycle allocVector has one bit per row at bit i*5+((i+1) mod 5).
REQ-034 Reset asserted mid-packet with output 1 LOCKED(2) -> next cycle allocVector=0, grant=0, and a new head from input 0 to output 1 is granted immediately.

Source files
------------

// File: rtl/switch_allocator_pkg.sv
// switch_allocator_pkg: shared router sizing, port encodings and lock state type
package switch_allocator_pkg;
  localparam int NUM_CHANNEL = 5;
  localparam int LOG_NUM_PORT = 3;
  typedef enum logic [LOG_NUM_PORT-1:0] {
    PORT_W      = 3'd0,
    PORT_E      = 3'd1,
    PORT_S      = 3'd2,
    PORT_N      = 3'd3,
    PORT_BYPASS = 3'd4
  } portE;
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lockStateE;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first request at or after ptr, wrapping around
module rr_arbiter import switch_allocator_pkg::*; #(
  parameter int N = NUM_CHANNEL,
  parameter int W = LOG_NUM_PORT
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt
);
  logic [N-1:0] rotReq;
  logic [N-1:0] first;
  // rotate so ptr sits at bit 0, isolate the lowest request, rotate back
  always_comb begin
    rotReq = N'({req, req} >> ptr);
    first = rotReq & (~rotReq + N'(1));
    gnt = N'(({first, first} << ptr) >> N);
  end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-output wormhole lock plus round-robin arbitration, registered crossbar map
module switch_allocator #(
  parameter int NUM_CHANNEL = switch_allocator_pkg::NUM_CHANNEL,
  parameter int LOG_NUM_PORT = switch_allocator_pkg::LOG_NUM_PORT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CHANNEL-1:0]              reqValid,
  input  logic [NUM_CHANNEL*LOG_NUM_PORT-1:0] reqDst,
  input  logic [NUM_CHANNEL-1:0]              reqTail,
  input  logic [NUM_CHANNEL-1:0]              outReady,
  output logic [NUM_CHANNEL-1:0]              grant,
  output logic [NUM_CHANNEL*NUM_CHANNEL-1:0]  allocVector
);
  logic [NUM_CHANNEL-1:0] outGnt [NUM_CHANNEL];
  logic [NUM_CHANNEL*NUM_CHANNEL-1:0] allocNext;
  for (genvar o = 0; o < NUM_CHANNEL; o++) begin : g_out
    switch_allocator_pkg::lockStateE state;
    logic [LOG_NUM_PORT-1:0] owner;
    logic [LOG_NUM_PORT-1:0] ptr;
    logic [LOG_NUM_PORT-1:0] gntIdx;
    logic [NUM_CHANNEL-1:0] cand;
    logic [NUM_CHANNEL-1:0] arbGnt;
    logic tailHit;
    // candidates: valid inputs whose destination field names this output; out-of-range codes never match
    always_comb begin
      cand = '0;
      for (int i = 0; i < NUM_CHANNEL; i++)
        cand[i] = reqValid[i] && (reqDst[i*LOG_NUM_PORT +: LOG_NUM_PORT] == LOG_NUM_PORT'(o));
    end
    rr_arbiter #(.N(NUM_CHANNEL), .W(LOG_NUM_PORT)) uArb (
      .req(cand),
      .ptr(ptr),
      .gnt(arbGnt)
    );
    // a locked output serves only its owner; reset and backpressure suppress every grant
    always_comb begin
      outGnt[o] = (reset || !outReady[o]) ? '0
                : (state == switch_allocator_pkg::LOCKED) ? (cand & (NUM_CHANNEL'(1) << owner))
                : arbGnt;
      tailHit = |(outGnt[o] & reqTail);
      gntIdx = '0;
      for (int i = 0; i < NUM_CHANNEL; i++)
        gntIdx = outGnt[o][i] ? LOG_NUM_PORT'(i) : gntIdx;
    end
    // head grants lock the output, tail grants release it and advance the pointer past the winner
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= switch_allocator_pkg::IDLE;
        owner <= '0;
        ptr <= '0;
      end else if (|outGnt[o]) begin
        state <= tailHit ? switch_allocator_pkg::IDLE : switch_allocator_pkg::LOCKED;
        owner <= gntIdx;
        if (tailHit)
          ptr <= (gntIdx == LOG_NUM_PORT'(NUM_CHANNEL-1)) ? '0 : gntIdx + LOG_NUM_PORT'(1);
      end
    end
  end
  // fold per-output grants into input grants and the input-major crossbar map
  always_comb begin
    grant = '0;
    allocNext = '0;
    for (int o = 0; o < NUM_CHANNEL; o++) begin
      grant = grant | outGnt[o];
      for (int i = 0; i < NUM_CHANNEL; i++)
        allocNext[i*NUM_CHANNEL+o] = outGnt[o][i];
    end
  end
  // crossbar control lags the grant by one cycle
  always_ff @(posedge clk) begin
    if (reset)
      allocVector <= '0;
    else
      allocVector <= allocNext;
  end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed vectors against a per-output lock/pointer model
module tb_switch_allocator;
  localparam int N = 5;
  localparam int W = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] reqValid = '0;
  logic [N-1:0] reqTail = '0;
  logic [N-1:0] outReady = '0;
  logic [N*W-1:0] reqDst = '0;
  logic [N-1:0] grant;
  logic [N*N-1:0] allocVector;
  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;
  int mLocked [N];
  int mOwner [N];
  int mPtr [N];
  logic [N*N-1:0] mAlloc = '0;

  always #5 clk = ~clk;

  switch_allocator #(.NUM_CHANNEL(N), .LOG_NUM_PORT(W)) dut (
    .clk(clk),
    .reset(reset),
    .reqValid(reqValid),
    .reqDst(reqDst),
    .reqTail(reqTail),
    .outReady(outReady),
    .grant(grant),
    .allocVector(allocVector)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dstOf(int i);
    return int'(reqDst[i*W +: W]);
  endfunction

  // who output o serves right now, -1 for nobody
  function automatic int winnerOf(int o);
    int w = -1;
    if (reset || !outReady[o]) return -1;
    if (mLocked[o] != 0)
      return (reqValid[mOwner[o]] && dstOf(mOwner[o]) == o) ? mOwner[o] : -1;
    for (int k = 0; k < N; k++) begin
      int i = (mPtr[o] + k) % N;
      if (w < 0 && reqValid[i] && dstOf(i) == o) w = i;
    end
    return w;
  endfunction

  function automatic logic [N-1:0] modelGrant();
    logic [N-1:0] g = '0;
    for (int o = 0; o < N; o++) begin
      int w = winnerOf(o);
      if (w >= 0) g[w] = 1'b1;
    end
    return g;
  endfunction

  initial for (int o = 0; o < N; o++) begin
    mLocked[o] = 0;
    mOwner[o] = 0;
    mPtr[o] = 0;
  end

  always @(posedge clk) begin
    int w [N];
    for (int o = 0; o < N; o++) w[o] = winnerOf(o);
    mAlloc = '0;
    for (int o = 0; o < N; o++) begin
      if (reset) begin
        mLocked[o] = 0;
        mOwner[o] = 0;
        mPtr[o] = 0;
      end else if (w[o] >= 0) begin
        mAlloc[w[o]*N + o] = 1'b1;
        if (reqTail[w[o]]) begin
          mLocked[o] = 0;
          mPtr[o] = (w[o] + 1) % N;
        end else begin
          mLocked[o] = 1;
          mOwner[o] = w[o];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      check("grant", 64'(grant), 64'(modelGrant()));
      check("allocVector", 64'(allocVector), 64'(mAlloc));
    end
  end

  task automatic step(logic [N-1:0] v, int d0, int d1, int d2, int d3, int d4,
                      logic [N-1:0] t, logic [N-1:0] r, logic rst);
    @(posedge clk);
    #1;
    reqValid = v;
    reqDst = {W'(d4), W'(d3), W'(d2), W'(d1), W'(d0)};
    reqTail = t;
    outReady = r;
    reset = rst;
    #3;
  endtask

  initial begin
    checkEn = 1'b1;
    step(5'b00101, 3, 0, 3, 0, 0, 5'b11111, 5'b11111, 1'b1);
    check("rstGrant", 64'(grant), 64'd0);
    step(5'b00101, 3, 0, 3, 0, 0, 5'b11111, 5'b11111, 1'b1);
    check("rstAlloc", 64'(allocVector), 64'd0);
    step(5'b00101, 3, 0, 3, 0, 0, 5'b11111, 5'b11111, 1'b0);
    check("rr1Grant", 64'(grant), 64'h01);
    step(5'b00101, 3, 0, 3, 0, 0, 5'b11111, 5'b11111, 1'b0);
    check("rr2Grant", 64'(grant), 64'h04);
    check("rr2Ptr", 64'(mPtr[3]), 64'd1);
    check("rr2Alloc", 64'(allocVector), 64'h8);
    step(5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111, 1'b0);
    check("rr3Alloc", 64'(allocVector), 64'h2000);
    check("rr3Ptr", 64'(mPtr[3]), 64'd3);
    step(5'b01010, 0, 4, 0, 4, 0, 5'b01000, 5'b11111, 1'b0);
    check("whHead", 64'(grant), 64'h02);
    step(5'b01010, 0, 4, 0, 4, 0, 5'b01000, 5'b11111, 1'b0);
    check("whBody", 64'(grant), 64'h02);
    step(5'b01010, 0, 4, 0, 4, 0, 5'b01010, 5'b11111, 1'b0);
    check("whTail", 64'(grant), 64'h02);
    step(5'b01000, 0, 4, 0, 4, 0, 5'b01000, 5'b11111, 1'b0);
    check("whNext", 64'(grant), 64'h08);
    check("whPtr", 64'(mPtr[4]), 64'd2);
    step(5'b10000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111, 1'b0);
    check("holdHead", 64'(grant), 64'h10);
    step(5'b10100, 0, 0, 0, 0, 0, 5'b00100, 5'b11110, 1'b0);
    check("holdBusy1", 64'(grant), 64'h00);
    step(5'b10100, 0, 0, 0, 0, 0, 5'b00100, 5'b11110, 1'b0);
    check("holdBusy2", 64'(grant), 64'h00);
    step(5'b00100, 0, 0, 0, 0, 0, 5'b00100, 5'b11111, 1'b0);
    check("holdGap", 64'(grant), 64'h00);
    step(5'b10100, 0, 0, 0, 0, 0, 5'b10100, 5'b11111, 1'b0);
    check("holdTail", 64'(grant), 64'h10);
    step(5'b00100, 0, 0, 0, 0, 0, 5'b00100, 5'b11111, 1'b0);
    check("holdAfter", 64'(grant), 64'h04);
    step(5'b01000, 0, 0, 0, 2, 0, 5'b01000, 5'b11111, 1'b0);
    check("wrapSetup", 64'(grant), 64'h08);
    step(5'b10001, 2, 0, 0, 0, 2, 5'b10001, 5'b11111, 1'b0);
    check("wrapPtr4", 64'(mPtr[2]), 64'd4);
    check("wrapFirst", 64'(grant), 64'h10);
    step(5'b10001, 2, 0, 0, 0, 2, 5'b10001, 5'b11111, 1'b0);
    check("wrapPtr0", 64'(mPtr[2]), 64'd0);
    check("wrapSecond", 64'(grant), 64'h01);
    step(5'b11111, 1, 2, 3, 4, 0, 5'b11111, 5'b11111, 1'b0);
    check("allGrant", 64'(grant), 64'h1f);
    step(5'b00111, 5, 6, 7, 0, 0, 5'b11111, 5'b11111, 1'b0);
    check("allAlloc", 64'(allocVector), 64'h0182082);
    check("badDst", 64'(grant), 64'h00);
    step(5'b00100, 0, 0, 1, 0, 0, 5'b00000, 5'b11111, 1'b0);
    check("midHead", 64'(grant), 64'h04);
    step(5'b00101, 1, 0, 1, 0, 0, 5'b00000, 5'b11111, 1'b1);
    check("midRstGrant", 64'(grant), 64'h00);
    step(5'b00101, 1, 0, 1, 0, 0, 5'b00000, 5'b11111, 1'b0);
    check("midRstAlloc", 64'(allocVector), 64'd0);
    check("midNewHead", 64'(grant), 64'h01);
    step(5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111, 1'b0);
    step(5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111, 1'b0);
    @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
